// File: rtl/tape_pkg.sv
// Shared types and default parameters for the cassette EAR input conditioner.
package tape_pkg;

    typedef enum logic {
        ACT_IDLE,
        ACT_ACTIVE
    } act_state_t;

    localparam int DEFAULT_FILTER_CYCLES = 64;
    localparam int DEFAULT_PW_WIDTH      = 16;
    localparam int DEFAULT_ACT_TIMEOUT   = 2700000;
    localparam int DEFAULT_ACT_WIDTH     = 24;

endpackage

// File: rtl/tape_glitch_filter.sv
// Synchronises the raw tape pin and accepts a new level only once it has
// persisted for FILTER_CYCLES consecutive cycles.
module tape_glitch_filter
    import tape_pkg::*;
#(
    parameter int FILTER_CYCLES = DEFAULT_FILTER_CYCLES
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic tape_in,
    output logic level,
    output logic accept,
    output logic edge_stb
);

    localparam int FCW = $clog2(FILTER_CYCLES);
    localparam logic [FCW-1:0] FCNT_LAST = FCW'(FILTER_CYCLES - 1);

    logic           s1;
    logic           s2;
    logic           filt;
    logic [FCW-1:0] fcnt;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= tape_in;
            s2 <= s1;
        end
    end

    // Exposed combinationally so the top can capture pulse data on the same
    // edge that filt toggles and edge_stb rises.
    assign accept = (s2 != filt) && (fcnt == FCNT_LAST);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            filt     <= 1'b0;
            fcnt     <= '0;
            edge_stb <= 1'b0;
        end else begin
            edge_stb <= 1'b0;
            if (s2 == filt) begin
                fcnt <= '0;
            end else if (accept) begin
                filt     <= ~filt;
                fcnt     <= '0;
                edge_stb <= 1'b1;
            end else begin
                fcnt <= fcnt + 1'b1;
            end
        end
    end

    assign level = filt;

endmodule

// File: rtl/tape_ear_conditioner.sv
// Clean EAR level for the guest core, plus per-edge pulse-width measurement
// and a tape activity flag for the LED.
module tape_ear_conditioner
    import tape_pkg::*;
#(
    parameter int FILTER_CYCLES = DEFAULT_FILTER_CYCLES,
    parameter int PW_WIDTH      = DEFAULT_PW_WIDTH,
    parameter int ACT_TIMEOUT   = DEFAULT_ACT_TIMEOUT,
    parameter int ACT_WIDTH     = DEFAULT_ACT_WIDTH
) (
    input  logic                clk_sys,
    input  logic                reset_n,
    input  logic                tape_in,
    input  logic                invert,
    output logic                ear_out,
    output logic                edge_stb,
    output logic [PW_WIDTH-1:0] pulse_len,
    output logic                pulse_level,
    output logic                overflow,
    output logic                activity
);

    localparam logic [ACT_WIDTH-1:0] ACNT_LAST = ACT_WIDTH'(ACT_TIMEOUT - 1);

    logic                 level;
    logic                 accept;
    logic [PW_WIDTH-1:0]  pcnt;
    logic [ACT_WIDTH-1:0] acnt;
    act_state_t           state;
    act_state_t           next_state;

    tape_glitch_filter #(
        .FILTER_CYCLES (FILTER_CYCLES)
    ) u_filter (
        .clk_sys  (clk_sys),
        .reset_n  (reset_n),
        .tape_in  (tape_in),
        .level    (level),
        .accept   (accept),
        .edge_stb (edge_stb)
    );

    assign ear_out = level ^ invert;

    // pcnt starts saturated so the first edge after reset reports overflow.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            pcnt        <= '1;
            pulse_len   <= '0;
            pulse_level <= 1'b0;
            overflow    <= 1'b0;
        end else if (accept) begin
            pulse_len   <= pcnt;
            overflow    <= (pcnt == '1);
            pulse_level <= level;
            pcnt        <= PW_WIDTH'(1);
        end else if (pcnt != '1) begin
            pcnt <= pcnt + 1'b1;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state <= ACT_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ACT_IDLE: begin
                if (accept) begin
                    next_state = ACT_ACTIVE;
                end
            end
            ACT_ACTIVE: begin
                if (!accept && (acnt == ACNT_LAST)) begin
                    next_state = ACT_IDLE;
                end
            end
            default: next_state = ACT_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            acnt <= '0;
        end else if (accept || (state != ACT_ACTIVE) || (acnt == ACNT_LAST)) begin
            acnt <= '0;
        end else begin
            acnt <= acnt + 1'b1;
        end
    end

    assign activity = (state == ACT_ACTIVE);

endmodule

// File: tb/tb_tape_ear_conditioner.sv
// Directed self-checking bench for tape_ear_conditioner with small parameters.
module tb_tape_ear_conditioner;

    localparam int FILTER_CYCLES = 4;
    localparam int PW_WIDTH      = 8;
    localparam int ACT_TIMEOUT   = 100;
    localparam int ACT_WIDTH     = 8;

    logic                clk_sys = 1'b0;
    logic                reset_n;
    logic                tape_in;
    logic                invert;
    logic                ear_out;
    logic                edge_stb;
    logic [PW_WIDTH-1:0] pulse_len;
    logic                pulse_level;
    logic                overflow;
    logic                activity;

    int compared   = 0;
    int mismatched = 0;
    int edge_count = 0;
    int edges_before;

    tape_ear_conditioner #(
        .FILTER_CYCLES (FILTER_CYCLES),
        .PW_WIDTH      (PW_WIDTH),
        .ACT_TIMEOUT   (ACT_TIMEOUT),
        .ACT_WIDTH     (ACT_WIDTH)
    ) dut (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .tape_in     (tape_in),
        .invert      (invert),
        .ear_out     (ear_out),
        .edge_stb    (edge_stb),
        .pulse_len   (pulse_len),
        .pulse_level (pulse_level),
        .overflow    (overflow),
        .activity    (activity)
    );

    always #5 clk_sys = ~clk_sys;

    // Count edge strobes at the falling edge, half a cycle after they are registered.
    always @(negedge clk_sys) begin
        if (edge_stb) edge_count++;
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int cycles);
        repeat (cycles) @(negedge clk_sys);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_ear"}, int'(ear_out), int'(invert));
        checkOutput({tag, "_stb"}, int'(edge_stb), 0);
        checkOutput({tag, "_len"}, int'(pulse_len), 0);
        checkOutput({tag, "_lvl"}, int'(pulse_level), 0);
        checkOutput({tag, "_ovf"}, int'(overflow), 0);
        checkOutput({tag, "_act"}, int'(activity), 0);
    endtask

    int exp_len [5] = '{7, 20, 20, 20, 20};
    int exp_lvl [5] = '{1, 0, 1, 0, 1};

    initial begin
        reset_n = 1'b0;
        tape_in = 1'b0;
        invert  = 1'b0;
        applyStimulus(2);
        checkResetState("reset");
        reset_n = 1'b1;
        applyStimulus(3);

        // First edge after reset: five cycles of latency, saturated pulse length.
        tape_in = 1'b1;
        applyStimulus(5);
        checkOutput("first_pre_ear", int'(ear_out), 0);
        checkOutput("first_pre_stb", int'(edge_stb), 0);
        applyStimulus(1);
        checkOutput("first_ear", int'(ear_out), 1);
        checkOutput("first_stb", int'(edge_stb), 1);
        checkOutput("first_len", int'(pulse_len), 255);
        checkOutput("first_ovf", int'(overflow), 1);
        checkOutput("first_lvl", int'(pulse_level), 0);
        checkOutput("first_act", int'(activity), 1);
        applyStimulus(1);
        checkOutput("first_stb_drop", int'(edge_stb), 0);

        // Quiet line: activity holds for 99 cycles, drops on the 100th.
        applyStimulus(98);
        checkOutput("timeout_99_act", int'(activity), 1);
        applyStimulus(1);
        checkOutput("timeout_100_act", int'(activity), 0);

        // Edge after 106 cycles re-arms activity and measures the gap.
        tape_in = 1'b0;
        applyStimulus(6);
        checkOutput("rearm_stb", int'(edge_stb), 1);
        checkOutput("rearm_len", int'(pulse_len), 106);
        checkOutput("rearm_ovf", int'(overflow), 0);
        checkOutput("rearm_lvl", int'(pulse_level), 1);
        checkOutput("rearm_ear", int'(ear_out), 0);
        checkOutput("rearm_act", int'(activity), 1);

        // Next edge lands exactly in the timeout cycle: activity must stay up.
        applyStimulus(94);
        tape_in = 1'b1;
        applyStimulus(5);
        checkOutput("late_pre_act", int'(activity), 1);
        checkOutput("late_pre_stb", int'(edge_stb), 0);
        applyStimulus(1);
        checkOutput("late_stb", int'(edge_stb), 1);
        checkOutput("late_len", int'(pulse_len), 100);
        checkOutput("late_act", int'(activity), 1);
        applyStimulus(1);
        checkOutput("late_post_act", int'(activity), 1);

        // Square wave of half-period 20; first edge is 7 cycles after the last one.
        for (int i = 0; i < 5; i++) begin
            tape_in = ~tape_in;
            applyStimulus(6);
            checkOutput($sformatf("sq%0d_stb", i), int'(edge_stb), 1);
            checkOutput($sformatf("sq%0d_len", i), int'(pulse_len), exp_len[i]);
            checkOutput($sformatf("sq%0d_lvl", i), int'(pulse_level), exp_lvl[i]);
            checkOutput($sformatf("sq%0d_ovf", i), int'(overflow), 0);
            applyStimulus(14);
        end
        checkOutput("sq_end_ear", int'(ear_out), 0);

        // Three-cycle high glitch on a low line is swallowed.
        edges_before = edge_count;
        tape_in = 1'b1;
        applyStimulus(3);
        tape_in = 1'b0;
        applyStimulus(8);
        checkOutput("glitch_edges", edge_count, edges_before);
        checkOutput("glitch_ear", int'(ear_out), 0);
        checkOutput("glitch_fcnt", int'(dut.u_filter.fcnt), 0);

        // Invert flips ear_out combinationally with no edge and no pulse update.
        invert = 1'b1;
        #1;
        checkOutput("inv_ear", int'(ear_out), 1);
        checkOutput("inv_stb", int'(edge_stb), 0);
        applyStimulus(1);
        checkOutput("inv_edges", edge_count, edges_before);
        checkOutput("inv_len", int'(pulse_len), 20);
        invert = 1'b0;
        #1;
        checkOutput("uninv_ear", int'(ear_out), 0);

        // Long gap saturates the pulse counter.
        applyStimulus(300);
        tape_in = 1'b1;
        applyStimulus(6);
        checkOutput("gap_stb", int'(edge_stb), 1);
        checkOutput("gap_len", int'(pulse_len), 255);
        checkOutput("gap_ovf", int'(overflow), 1);
        checkOutput("gap_lvl", int'(pulse_level), 0);
        applyStimulus(1);
        checkOutput("edge_total", edge_count, 9);

        // Asynchronous reset in the middle of a filter window.
        tape_in = 1'b0;
        applyStimulus(3);
        #2 reset_n = 1'b0;
        #1;
        checkResetState("midreset");
        invert = 1'b1;
        #1;
        checkOutput("midreset_inv_ear", int'(ear_out), 1);
        invert = 1'b0;
        applyStimulus(2);
        reset_n = 1'b1;
        applyStimulus(3);
        checkOutput("postreset_stb", int'(edge_stb), 0);
        checkOutput("postreset_ear", int'(ear_out), 0);
        tape_in = 1'b1;
        applyStimulus(6);
        checkOutput("postreset_first_stb", int'(edge_stb), 1);
        checkOutput("postreset_first_len", int'(pulse_len), 255);
        checkOutput("postreset_first_ovf", int'(overflow), 1);
        checkOutput("postreset_first_act", int'(activity), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/tape_ear_conditioner.md
# tape_ear_conditioner

Conditions the raw cassette input pin of the Jupiter Ace MiST core before it reaches the guest's EAR/serial input. It synchronises the asynchronous pin, rejects glitches shorter than a programmable width and emits a clean, optionally inverted EAR level. It also provides per-edge pulse-width measurement for loader diagnostics and an activity flag for the yellow LED. It sits between the top-level tape pin and the guest core input.

## Interface
Parameters:
- FILTER_CYCLES, 64: cycles a new level must persist before it is accepted (≥2).
- PW_WIDTH, 16: width of the pulse-length counter/output.
- ACT_TIMEOUT, 2700000: cycles without an edge before activity drops (100 ms at 27 MHz).
- ACT_WIDTH, 24: width of the activity counter; must hold ACT_TIMEOUT.

Ports:
- clk_sys  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- tape_in  in  1  raw pin, asynchronous to clk_sys.
- invert  in  1  quasi-static; 1 = invert ear_out polarity.
- ear_out  out  1  filtered level XOR invert, to the guest input.
- edge_stb  out  1  one-cycle pulse on each accepted level change.
- pulse_len  out  PW_WIDTH  cycles between the previous and current accepted edge; valid from edge_stb, held until next.
- pulse_level  out  1  filtered level (pre-invert) during the measured pulse.
- overflow  out  1  pulse_len saturated for the measured pulse.
- activity  out  1  1 while edges arrive within ACT_TIMEOUT.

## Operation
- Sync: 2-flop synchroniser s1→s2, both reset to 0.
- Filter: register filt (reset 0), counter fcnt. fcnt clears whenever s2==filt. It increments whenever s2!=filt. When s2!=filt and fcnt==FILTER_CYCLES-1, filt toggles, fcnt clears and edge_stb asserts for that same registered cycle.
- A level returning before acceptance clears fcnt, so pulses shorter than FILTER_CYCLES are swallowed.
- ear_out = filt ^ invert. Changing invert flips ear_out immediately and creates no edge_stb.
- Pulse counter pcnt resets to all-ones (saturated). On an edge: pulse_len←pcnt, overflow←(pcnt==all-ones), pulse_level←old filt, pcnt←1. Otherwise pcnt increments, saturating at all-ones.
- Consequently the first edge after reset reports pulse_len=2^PW_WIDTH-1 with overflow=1.
- Activity FSM, states IDLE and ACTIVE, reset to IDLE. acnt clears on every edge.
  - IDLE→ACTIVE on edge_stb.
  - ACTIVE→IDLE when acnt==ACT_TIMEOUT-1 with no edge in that cycle. acnt otherwise increments.
  - An edge in the timeout cycle keeps ACTIVE and clears acnt.
- activity = (state==ACTIVE).

## Timing
- Reset values: ear_out=invert, edge_stb=0, pulse_len=0, pulse_level=0, overflow=0, activity=0, pcnt=all-ones.
- Latency: tape_in stable from before edge k gives s2 changed after edge k+1. filt/ear_out/edge_stb change after edge k+1+FILTER_CYCLES. Total 2+FILTER_CYCLES-1 cycles of delay, uncertainty ±1 cycle from async sampling.
- Steady square wave of half-period P ≥ FILTER_CYCLES cycles gives pulse_len=P on every edge after the first.
- activity rises with the first edge_stb, same cycle the registered state updates.
- activity falls exactly ACT_TIMEOUT cycles after the last edge_stb.
- reset_n low mid-pulse clears all state asynchronously. After release, behaviour is identical to power-up.

## Structure
- Package tape_pkg: enum act_state_t {ACT_IDLE, ACT_ACTIVE}, default-width localparams.
- Sub-module tape_glitch_filter (synchroniser + fcnt + filt, outputs level and edge strobe). The top instantiates it and adds pcnt and the activity FSM.

## Test plan
All scenarios use FILTER_CYCLES=4, PW_WIDTH=8, ACT_TIMEOUT=100.
- Reset then tape_in 0→1 held → ear_out rises 5 cycles after the sampled change, one edge_stb, pulse_len=255, overflow=1, pulse_level=0, activity=1.
- Square wave, half-period 20 cycles → from the second edge, pulse_len=20, overflow=0, pulse_level alternating 1/0.
- 3-cycle high glitch on a low line → no edge_stb, ear_out constant, fcnt returns to 0.
- invert toggled with tape_in static → ear_out flips within one cycle, no edge_stb, pulse outputs unchanged.
- Single edge then quiet → activity falls exactly 100 cycles after edge_stb. Edge injected at cycle 99 → activity stays 1.
- Gap of 300 cycles between edges → pulse_len=255, overflow=1. reset_n pulsed mid-wave → all outputs return to reset values immediately.
